// File: rtl/hist2d_bin_coord.sv
// hist2d_bin_coord: converts one signed I/Q sample pair into 2D histogram bin
// coordinates, coord = (val - min) / bin_width limited to [0, bin_num-1].
// Optional build macro HIST2D_OOR_DROP_EN: out-of-range pairs are dropped
// (no strobe, coords hold) and counted on oor_count instead of being clamped.
module hist2d_bin_coord #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned COORD_W  = 8
) (
    input  logic                clk100,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] i_val,
    input  logic [SAMPLE_W-1:0] q_val,
    input  logic [SAMPLE_W-1:0] i_min,
    input  logic [SAMPLE_W-1:0] q_min,
    input  logic [SAMPLE_W-1:0] i_bin_width,
    input  logic [SAMPLE_W-1:0] q_bin_width,
    input  logic [COORD_W-1:0]  i_bin_num,
    input  logic [COORD_W-1:0]  q_bin_num,
    output logic                busy,
    output logic                data_out,
    output logic [COORD_W-1:0]  i_bin_coord,
    output logic [COORD_W-1:0]  q_bin_coord,
    output logic [15:0]         drop_count
`ifdef HIST2D_OOR_DROP_EN
    ,
    output logic [15:0]         oor_count
`endif
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_W + 1);
    localparam int unsigned NAXIS = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SUB,
        S_DIV,
        S_LIM,
        S_OUT
    } state_t;

    state_t              state_q;
    logic                busy_q;
    logic                data_out_q;
    logic [15:0]         drop_q;
    logic [CNT_W-1:0]    cnt_q;

    // Per-axis latched operands and divider state (index 0 = I, 1 = Q)
    logic [SAMPLE_W-1:0] val_q   [NAXIS];
    logic [SAMPLE_W-1:0] min_q   [NAXIS];
    logic [SAMPLE_W-1:0] width_q [NAXIS];
    logic [COORD_W-1:0]  num_q   [NAXIS];
    logic                below_q [NAXIS];
    logic [SAMPLE_W-1:0] rem_q   [NAXIS];
    logic [SAMPLE_W-1:0] quo_q   [NAXIS];
    logic [COORD_W-1:0]  coord_q [NAXIS];

    logic [SAMPLE_W:0]   diff_d   [NAXIS];
    logic [SAMPLE_W:0]   shift_d  [NAXIS];
    logic [SAMPLE_W-1:0] rem_d    [NAXIS];
    logic [SAMPLE_W-1:0] quo_d    [NAXIS];
    logic [COORD_W-1:0]  top_d    [NAXIS];
    logic                over_d   [NAXIS];
    logic [COORD_W-1:0]  lim_d    [NAXIS];

`ifdef HIST2D_OOR_DROP_EN
    logic [15:0]         oor_q;
    logic                oor_any_d;
`endif

    // Subtract, one restoring-divide step and limiting, per axis
    always_comb begin
        for (int a = 0; a < int'(NAXIS); a++) begin
            diff_d[a]  = '0;
            shift_d[a] = '0;
            rem_d[a]   = '0;
            quo_d[a]   = '0;
            top_d[a]   = '0;
            over_d[a]  = 1'b0;
            lim_d[a]   = '0;

            diff_d[a]  = {val_q[a][SAMPLE_W-1], val_q[a]} - {min_q[a][SAMPLE_W-1], min_q[a]};

            shift_d[a] = {rem_q[a], quo_q[a][SAMPLE_W-1]};
            if (shift_d[a] >= {1'b0, width_q[a]}) begin
                rem_d[a] = SAMPLE_W'(shift_d[a] - {1'b0, width_q[a]});
                quo_d[a] = {quo_q[a][SAMPLE_W-2:0], 1'b1};
            end else begin
                rem_d[a] = shift_d[a][SAMPLE_W-1:0];
                quo_d[a] = {quo_q[a][SAMPLE_W-2:0], 1'b0};
            end

            top_d[a]  = (num_q[a] == '0) ? '0 : COORD_W'(num_q[a] - COORD_W'(1));
            over_d[a] = quo_q[a] > SAMPLE_W'(top_d[a]);
            if (below_q[a]) begin
                lim_d[a] = '0;
            end else if (over_d[a]) begin
                lim_d[a] = top_d[a];
            end else begin
                lim_d[a] = quo_q[a][COORD_W-1:0];
            end
        end
`ifdef HIST2D_OOR_DROP_EN
        oor_any_d = below_q[0] | below_q[1] | over_d[0] | over_d[1];
`endif
    end

    // Conversion FSM with drop counting and registered outputs
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            data_out_q <= 1'b0;
            drop_q     <= '0;
            cnt_q      <= '0;
            for (int a = 0; a < int'(NAXIS); a++) begin
                val_q[a]   <= '0;
                min_q[a]   <= '0;
                width_q[a] <= '0;
                num_q[a]   <= '0;
                below_q[a] <= 1'b0;
                rem_q[a]   <= '0;
                quo_q[a]   <= '0;
                coord_q[a] <= '0;
            end
`ifdef HIST2D_OOR_DROP_EN
            oor_q      <= '0;
`endif
        end else begin
            data_out_q <= 1'b0;

            if (sample_valid && busy_q && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (sample_valid) begin
                        val_q[0]   <= i_val;
                        val_q[1]   <= q_val;
                        min_q[0]   <= i_min;
                        min_q[1]   <= q_min;
                        width_q[0] <= i_bin_width;
                        width_q[1] <= q_bin_width;
                        num_q[0]   <= i_bin_num;
                        num_q[1]   <= q_bin_num;
                        busy_q     <= 1'b1;
                        state_q    <= S_SUB;
                    end
                end
                S_SUB: begin
                    for (int a = 0; a < int'(NAXIS); a++) begin
                        below_q[a] <= diff_d[a][SAMPLE_W];
                        quo_q[a]   <= diff_d[a][SAMPLE_W-1:0];
                        rem_q[a]   <= '0;
                    end
                    cnt_q   <= '0;
                    state_q <= S_DIV;
                end
                S_DIV: begin
                    for (int a = 0; a < int'(NAXIS); a++) begin
                        rem_q[a] <= rem_d[a];
                        quo_q[a] <= quo_d[a];
                    end
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(SAMPLE_W - 1)) begin
                        state_q <= S_LIM;
                    end
                end
                S_LIM: begin
`ifdef HIST2D_OOR_DROP_EN
                    if (oor_any_d) begin
                        if (oor_q != 16'hFFFF) begin
                            oor_q <= oor_q + 16'd1;
                        end
                    end else begin
                        data_out_q <= 1'b1;
                        coord_q[0] <= lim_d[0];
                        coord_q[1] <= lim_d[1];
                    end
`else
                    data_out_q <= 1'b1;
                    coord_q[0] <= lim_d[0];
                    coord_q[1] <= lim_d[1];
`endif
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign data_out    = data_out_q;
    assign i_bin_coord = coord_q[0];
    assign q_bin_coord = coord_q[1];
    assign drop_count  = drop_q;
`ifdef HIST2D_OOR_DROP_EN
    assign oor_count   = oor_q;
`endif

endmodule
